cp0_irq_timer: RTL

//  Parametrised CP0 interrupt/timer unit: Count plus NUM_TIMERS Compare channels, per-line

---
 rtl/cp0_pkg.sv | 32 +++
 rtl/cp0_irq_sync.sv | 27 ++
 rtl/cp0_irq_timer.sv | 110 +++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 interrupt constants, Status/Cause field positions and exception codes
package cp0_pkg;
  localparam int IP_SW0 = 0;
  localparam int IP_SW1 = 1;
  localparam int IP_HW0 = 2;
  localparam int IP_TIMER0 = 7;
  localparam int ST_IE = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_IM = 8;
  localparam int CAUSE_EXC = 2;
  localparam int CAUSE_IP = 8;
  localparam int CAUSE_TI = 30;
  localparam int CAUSE_BD = 31;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } excCode_t;
  function automatic int timerBase(input int numHw);
    return IP_HW0 + numHw;
  endfunction
endpackage

// File: rtl/cp0_irq_sync.sv
// cp0_irq_sync: synchronises one external interrupt line and captures it as level or rising edge
module cp0_irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irqIn,
  input  logic ack,
  output logic pending
);
  logic [SYNC_STAGES-1:0] syncQ;
  logic lastQ;
  logic synced;
  assign synced = syncQ[SYNC_STAGES-1];
  // edge capture sticks until acknowledged; a new edge in the ack cycle wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      syncQ <= '0;
      lastQ <= 1'b0;
      pending <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], irqIn};
      lastQ <= synced;
      pending <= EDGE ? (synced & ~lastQ) | (pending & ~ack) : synced;
    end
endmodule

// File: rtl/cp0_irq_timer.sv
// cp0_irq_timer: Count/Compare timers, external line capture and prioritised interrupt request
module cp0_irq_timer
  import cp0_pkg::*;
#(
  parameter int NUM_HW_IRQ = 5,
  parameter int NUM_TIMERS = 1,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV = 1,
  parameter logic [NUM_HW_IRQ-1:0] EDGE_MASK = '0,
  localparam int NUM_IP = 2 + NUM_HW_IRQ + NUM_TIMERS,
  localparam int VW = $clog2(NUM_IP)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic [NUM_HW_IRQ-1:0]   irq_in,
  input  logic [1:0]              sw_ip,
  input  logic [NUM_IP-1:0]       im,
  input  logic                    ie,
  input  logic                    exl,
  input  logic                    erl,
  input  logic                    count_we,
  input  logic [NUM_TIMERS-1:0]   cmp_we,
  input  logic [31:0]             wdata,
  input  logic                    irq_ack,
  output logic [31:0]             count,
  output logic [32*NUM_TIMERS-1:0] compare,
  output logic [NUM_IP-1:0]       ip,
  output logic                    ti,
  output logic                    interrupt,
  output logic [VW-1:0]           irq_vec
);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  logic [PW-1:0] presc;
  logic tick;
  logic countWe;
  logic ackOk;
  logic [NUM_TIMERS-1:0] timerPend;
  logic [NUM_HW_IRQ-1:0] hwPend;
  logic [NUM_IP-1:0] masked;
  logic [VW-1:0] hiIdx;
  logic req;
  assign tick = presc == PW'(COUNT_DIV - 1);
  assign countWe = count_we & ~stall;
  assign ackOk = irq_ack & ~stall;
  // Count keeps running through stalls; only the MTC0 write is stall-gated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      presc <= '0;
    end else if (countWe) begin
      count <= wdata;
      presc <= '0;
    end else begin
      count <= count + {31'd0, tick};
      presc <= tick ? '0 : presc + PW'(1);
    end
  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
    logic [31:0] cmpQ;
    logic matchQ;
    logic pend;
    logic match;
    assign match = count == cmpQ;
    assign compare[32*k +: 32] = cmpQ;
    assign timerPend[k] = pend;
    // matchQ resets high so count==compare==0 out of reset is not a fresh match
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cmpQ <= '0;
        matchQ <= 1'b1;
        pend <= 1'b0;
      end else begin
        matchQ <= match;
        if (cmp_we[k] & ~stall) begin
          cmpQ <= wdata;
          pend <= 1'b0;
        end else if (match & ~matchQ)
          pend <= 1'b1;
      end
  end
  for (genvar i = 0; i < NUM_HW_IRQ; i++) begin : g_hw
    cp0_irq_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE(EDGE_MASK[i])
    ) u_sync (
      .clk(clk),
      .rst_n(rst_n),
      .irqIn(irq_in[i]),
      .ack(ackOk && irq_vec == VW'(IP_HW0 + i)),
      .pending(hwPend[i])
    );
  end
  assign ip = {timerPend, hwPend, sw_ip};
  assign ti = |timerPend;
  assign masked = ip & im;
  assign req = |masked & ie & ~exl & ~erl;
  always_comb begin
    hiIdx = '0;
    for (int j = 0; j < NUM_IP; j++)
      hiIdx = masked[j] ? VW'(j) : hiIdx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      interrupt <= 1'b0;
      irq_vec <= '0;
    end else begin
      interrupt <= req;
      irq_vec <= |masked ? hiIdx : irq_vec;
    end
endmodule
